// File: rtl/mux_8x1_pkg.sv
// Shared constants and select-bit weighting for the registered 8:1 multiplexer.
// The weighting lives in sel_index so every user agrees that S1 is the LSB.
package mux_8x1_pkg;

  localparam int SEL_W      = 3;
  localparam int NUM_INPUTS = 8;

  // S2 has weight 4, S0 weight 2 and S1 weight 1; the swapped middle/low bits are intentional.
  function automatic logic [SEL_W-1:0] sel_index(input logic s2, input logic s1, input logic s0);
    return {s2, s0, s1};
  endfunction

endpackage

// File: rtl/mux_8x1_comb.sv
// Pure combinational WIDTH-bit 8:1 selection; exactly one input is routed, with no priority.
module mux_8x1_comb
  import mux_8x1_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic [SEL_W-1:0] idx,
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  input  logic [WIDTH-1:0] i2,
  input  logic [WIDTH-1:0] i3,
  input  logic [WIDTH-1:0] i4,
  input  logic [WIDTH-1:0] i5,
  input  logic [WIDTH-1:0] i6,
  input  logic [WIDTH-1:0] i7,
  output logic [WIDTH-1:0] sel_data
);

  logic [WIDTH-1:0] data [NUM_INPUTS];

  assign data[0] = i0;
  assign data[1] = i1;
  assign data[2] = i2;
  assign data[3] = i3;
  assign data[4] = i4;
  assign data[5] = i5;
  assign data[6] = i6;
  assign data[7] = i7;

  always_comb begin
    sel_data = data[idx];
  end

endmodule

// File: rtl/mux_8x1.sv
// Registered 8:1 multiplexer: the selected input is captured into Y on each rising CLK.
// RST clears Y immediately, independent of the clock.
module mux_8x1
  import mux_8x1_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             S2,
  input  logic             S1,
  input  logic             S0,
  input  logic [WIDTH-1:0] I0,
  input  logic [WIDTH-1:0] I1,
  input  logic [WIDTH-1:0] I2,
  input  logic [WIDTH-1:0] I3,
  input  logic [WIDTH-1:0] I4,
  input  logic [WIDTH-1:0] I5,
  input  logic [WIDTH-1:0] I6,
  input  logic [WIDTH-1:0] I7,
  output logic [WIDTH-1:0] Y
);

  logic [SEL_W-1:0] idx;
  logic [WIDTH-1:0] sel_data;

  assign idx = sel_index(S2, S1, S0);

  mux_8x1_comb #(
    .WIDTH(WIDTH)
  ) u_comb (
    .idx     (idx),
    .i0      (I0),
    .i1      (I1),
    .i2      (I2),
    .i3      (I3),
    .i4      (I4),
    .i5      (I5),
    .i6      (I6),
    .i7      (I7),
    .sel_data(sel_data)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      Y <= '0;
    end else begin
      Y <= sel_data;
    end
  end

endmodule

// File: tb/tb_mux_8x1.sv
// Directed, table-driven bench for mux_8x1 at WIDTH=4, plus hand-written reset and latency sequences.
module tb_mux_8x1;

  localparam int W = 4;

  logic         CLK;
  logic         RST;
  logic         S2;
  logic         S1;
  logic         S0;
  logic [W-1:0] I0, I1, I2, I3, I4, I5, I6, I7;
  logic [W-1:0] Y;

  int compared;
  int mismatched;

  typedef struct {
    string           name;
    logic [2:0]      sel;   // {S2,S1,S0}
    logic [7:0][W-1:0] data; // data[k] drives Ik
    logic [W-1:0]    y;
  } vec_t;

  vec_t vecs[$];

  mux_8x1 #(
    .WIDTH(W)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .S2 (S2),
    .S1 (S1),
    .S0 (S0),
    .I0 (I0),
    .I1 (I1),
    .I2 (I2),
    .I3 (I3),
    .I4 (I4),
    .I5 (I5),
    .I6 (I6),
    .I7 (I7),
    .Y  (Y)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic setInputs(input logic [2:0] sel, input logic [7:0][W-1:0] data);
    {S2, S1, S0} = sel;
    I0 = data[0]; I1 = data[1]; I2 = data[2]; I3 = data[3];
    I4 = data[4]; I5 = data[5]; I6 = data[6]; I7 = data[7];
  endtask

  task automatic applyStimulus(input logic [2:0] sel, input logic [7:0][W-1:0] data);
    @(negedge CLK);
    setInputs(sel, data);
  endtask

  task automatic checkOutput(input string name, input logic [W-1:0] expected);
    compared++;
    if (Y !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: Y=%h expected %h", name, Y, expected);
    end
  endtask

  task automatic addVec(input string name, input logic [2:0] sel,
                        input logic [7:0][W-1:0] data, input logic [W-1:0] y);
    vec_t v;
    v.name = name;
    v.sel  = sel;
    v.data = data;
    v.y    = y;
    vecs.push_back(v);
  endtask

  initial begin
    logic [2:0] sel_tab [8];
    compared   = 0;
    mismatched = 0;

    // (S2,S1,S0) that selects input k, written out from the mapping table.
    sel_tab = '{3'b000, 3'b010, 3'b001, 3'b011, 3'b100, 3'b110, 3'b101, 3'b111};

    for (int k = 0; k < 8; k++) begin
      addVec($sformatf("onehot_i%0d", k), sel_tab[k], 32'h0000_000F << (4 * k), 4'hF);
    end
    for (int k = 0; k < 8; k++) begin
      addVec($sformatf("isolate_i%0d", k), sel_tab[k], ~(32'h0000_000F << (4 * k)), 4'h0);
    end
    // Distinct values I0..I7 = 1,4,7,A,D,0,3,6.
    addVec("pattern_000", 3'b000, 32'h630D_A741, 4'h1);
    addVec("pattern_010", 3'b010, 32'h630D_A741, 4'h4);
    addVec("pattern_001", 3'b001, 32'h630D_A741, 4'h7);
    addVec("pattern_011", 3'b011, 32'h630D_A741, 4'hA);
    addVec("pattern_100", 3'b100, 32'h630D_A741, 4'hD);
    addVec("pattern_110", 3'b110, 32'h630D_A741, 4'h0);
    addVec("pattern_101", 3'b101, 32'h630D_A741, 4'h3);
    addVec("pattern_111", 3'b111, 32'h630D_A741, 4'h6);

    // Reset asserted between edges clears Y at once and holds it across edges.
    RST = 1'b0;
    setInputs(3'b000, 32'hFFFF_FFFF);
    #2;
    RST = 1'b1;
    #1;
    checkOutput("reset_immediate", 4'h0);
    repeat (2) @(posedge CLK);
    #1;
    checkOutput("reset_hold", 4'h0);

    // First edge after release loads the selected input.
    @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK);
    #1;
    checkOutput("reset_release_load", 4'hF);

    foreach (vecs[n]) begin
      applyStimulus(vecs[n].sel, vecs[n].data);
      @(posedge CLK);
      #1;
      checkOutput(vecs[n].name, vecs[n].y);
    end

    // Latency: 000 then 111 on consecutive edges with I0=F, I7=0.
    applyStimulus(3'b000, 32'h0000_000F);
    @(posedge CLK);
    #1;
    checkOutput("latency_sel000", 4'hF);
    @(negedge CLK);
    checkOutput("latency_hold_before_edge", 4'hF);
    setInputs(3'b111, 32'h0000_000F);
    #1;
    checkOutput("latency_no_comb_path", 4'hF);
    @(posedge CLK);
    #1;
    checkOutput("latency_sel111", 4'h0);
    @(posedge CLK);
    #1;
    checkOutput("latency_stays_0", 4'h0);

    // Mid-run reset pulse between edges.
    applyStimulus(3'b000, 32'h0000_0009);
    @(posedge CLK);
    #1;
    checkOutput("midrun_before_reset", 4'h9);
    #2;
    RST = 1'b1;
    #1;
    checkOutput("midrun_reset_clears", 4'h0);
    #1;
    RST = 1'b0;
    #1;
    checkOutput("midrun_after_release_wait", 4'h0);
    @(posedge CLK);
    #1;
    checkOutput("midrun_reload", 4'h9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
